// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one shift-and-subtract step per clock.
// A start is accepted in IDLE or DONE, so back-to-back divisions have no bubble.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: start is taken on a rising edge whenever busy=0; valid is a
    // single-cycle pulse and the results stay put until the next accepted start.
    state_t           state, state_nx;
    logic [WIDTH-1:0] q_reg, q_nx;
    logic [WIDTH-1:0] d_reg, d_nx;
    logic [WIDTH-1:0] r_reg, r_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] quo_nx, rem_nx;
    logic             dz_nx;
    logic [WIDTH:0]   shift_r;
    logic [WIDTH:0]   trial;

    // The partial remainder is always restored below D, so its top bit of the
    // WIDTH+1-bit R is zero between steps and only the shifted value needs it.
    always_comb begin
        state_nx = state;
        q_nx     = q_reg;
        d_nx     = d_reg;
        r_nx     = r_reg;
        cnt_nx   = cnt;
        quo_nx   = quotient;
        rem_nx   = remainder;
        dz_nx    = div_by_zero;
        shift_r  = {r_reg, q_reg[WIDTH-1]};
        trial    = shift_r - {1'b0, d_reg};

        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (start) begin
                    if (divisor != '0) begin
                        state_nx = RUN;
                        q_nx     = dividend;
                        d_nx     = divisor;
                        r_nx     = '0;
                        cnt_nx   = CW'(WIDTH);
                    end else begin
                        state_nx = DONE;
                        quo_nx   = '1;
                        rem_nx   = dividend;
                        dz_nx    = 1'b1;
                    end
                end
            end
            RUN: begin
                q_nx   = {q_reg[WIDTH-2:0], ~trial[WIDTH]};
                r_nx   = trial[WIDTH] ? shift_r[WIDTH-1:0] : trial[WIDTH-1:0];
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx = DONE;
                    quo_nx   = q_nx;
                    rem_nx   = r_nx;
                    dz_nx    = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nx;
            q_reg       <= q_nx;
            d_reg       <= d_nx;
            r_reg       <= r_nx;
            cnt         <= cnt_nx;
            quotient    <= quo_nx;
            remainder   <= rem_nx;
            div_by_zero <= dz_nx;
        end
    end

    assign busy      = (state == RUN);
    assign valid     = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider (WIDTH=32): results, latency,
// divide-by-zero, ignored starts, back-to-back issue and mid-division reset.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .valid      (valid),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .dbg_state  (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one start and returns edges counted from the sampling edge
    // (inclusive) until valid is seen, bounded at 100.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 1;
        while (!valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic edz, input int elat);
        int lat;
        run_div(a, b, lat);
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_valid"}, 64'(valid), 64'd1);
        check({tag, "_busy_in_valid"}, 64'(busy), 64'd0);
        check({tag, "_quo"}, 64'(quotient), 64'(eq));
        check({tag, "_rem"}, 64'(remainder), 64'(er));
        check({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
    endtask

    initial begin
        int pulses;
        int vlat;
        int lat;
        logic [W-1:0] a, b;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_quo", 64'(quotient), 64'd0);
        check("rst_rem", 64'(remainder), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: basic division and latency
        check_div("t1_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);

        // 2: max dividend, then back-to-back issue in the valid cycle
        check_div("t2_max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        check_div("t2_3_10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33);

        // 3: divide by zero, then a normal result clears the flag
        check_div("t3_5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        check_div("t3_9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

        // 4: start while busy is ignored; previous result held during RUN
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd10;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        vlat   = 0;
        for (int i = 2; i <= 45; i++) begin
            @(negedge clk);
            if (i == 5) begin
                start    = 1'b1;
                dividend = 32'd7;
                divisor  = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i == 10) begin
                check("t4_held_quo", 64'(quotient), 64'd3);
                check("t4_busy", 64'(busy), 64'd1);
            end
            if (valid) begin
                pulses++;
                vlat = i;
                check("t4_quo", 64'(quotient), 64'd100);
                check("t4_rem", 64'(remainder), 64'd0);
            end
        end
        start = 1'b0;
        check("t4_pulses", 64'(pulses), 64'd1);
        check("t4_lat", 64'(vlat), 64'd33);

        // 5: asynchronous reset mid-division
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'h8000_0000;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_valid", 64'(valid), 64'd0);
        check("t5_quo", 64'(quotient), 64'd0);
        check("t5_rem", 64'(remainder), 64'd0);
        check("t5_dz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid) pulses++;
        end
        check("t5_no_valid", 64'(pulses), 64'd0);
        check_div("t5_6_4", 32'd6, 32'd4, 32'd1, 32'd2, 1'b0, 33);

        // Boundary operands
        check_div("b_7_7", 32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 33);
        check_div("b_0_5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33);
        check_div("b_1_max", 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 33);
        check_div("b_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33);
        check_div("b_0_0", 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);
        check_div("b_1000_33", 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 33);

        // 6: random pairs, invariant and latency
        for (int n = 0; n < 200; n++) begin
            a = $urandom;
            b = (n % 3 == 0) ? W'($urandom_range(1, 15)) : $urandom;
            if (b == '0) b = 32'd1;
            run_div(a, b, lat);
            check("rnd_lat", 64'(lat), 64'd33);
            check("rnd_identity", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
            check("rnd_rem_lt_div", 64'(remainder < b), 64'd1);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
